// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-stage initiator with alignment checking,
// lane steering, req/gnt/rvalid handshake, load extension and timeout.
module load_store_unit #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        load_valid_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o,
    output logic        timeout_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CW =
        (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles);
    localparam logic [CW-1:0] CntMax = CW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [31:0]   addr_q, wdata_q, load_data_q;
    logic [3:0]    be_q;
    logic          load_valid_q, misalign_q, timeout_q;

    logic          legal, expired, accept, stall_c;
    logic          gnt_to, rv_to;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d, ext_d;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;

    always_comb begin
        legal = 1'b0;
        unique case (req_funct3_i)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~req_addr_i[0];
            3'b010:  legal = (req_addr_i[1:0] == 2'b00);
            3'b100:  legal = ~req_we_i;
            3'b101:  legal = ~req_we_i & ~req_addr_i[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        be_d    = 4'b0000;
        wdata_d = 32'h0;
        unique case (req_funct3_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << req_addr_i[1:0];
                wdata_d = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                be_d    = req_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{req_wdata_i[15:0]}};
            end
            2'b10: begin
                be_d    = 4'b1111;
                wdata_d = req_wdata_i;
            end
            default: begin
                be_d    = 4'b0000;
                wdata_d = 32'h0;
            end
        endcase
        if (!req_we_i)
            wdata_d = 32'h0;
    end

    always_comb begin
        rbyte = 8'h00;
        unique case (off_q)
            2'd0: rbyte = mem_rdata_i[7:0];
            2'd1: rbyte = mem_rdata_i[15:8];
            2'd2: rbyte = mem_rdata_i[23:16];
            2'd3: rbyte = mem_rdata_i[31:24];
        endcase
        rhalf = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        ext_d = mem_rdata_i;
        unique case (f3_q)
            3'b000:  ext_d = {{24{rbyte[7]}}, rbyte};
            3'b001:  ext_d = {{16{rhalf[15]}}, rhalf};
            3'b100:  ext_d = {24'h0, rbyte};
            3'b101:  ext_d = {16'h0, rhalf};
            default: ext_d = mem_rdata_i;
        endcase
    end

    assign expired = (cnt_q == CntMax);
    assign gnt_to  = (state_q == REQ) & ~mem_gnt_i & expired;
    assign rv_to   = (state_q == WAIT_R) & ~mem_rvalid_i & expired;

    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i && legal) begin
                    accept  = 1'b1;
                    stall_c = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_d = we_q ? IDLE : WAIT_R;
                    stall_c = ~we_q;
                end else if (expired) begin
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            WAIT_R: begin
                if (mem_rvalid_i || expired)
                    state_d = IDLE;
                else
                    stall_c = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q != IDLE)
                cnt_q <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            addr_q       <= 32'h0;
            be_q         <= 4'b0000;
            wdata_q      <= 32'h0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we_i;
                f3_q    <= req_funct3_i;
                off_q   <= req_addr_i[1:0];
                addr_q  <= {req_addr_i[31:2], 2'b00};
                be_q    <= be_d;
                wdata_q <= wdata_d;
            end
            load_valid_q <= (state_q == WAIT_R) & mem_rvalid_i;
            if ((state_q == WAIT_R) && mem_rvalid_i)
                load_data_q <= ext_d;
            misalign_q <= (state_q == IDLE) & req_valid_i & ~legal;
            timeout_q  <= gnt_to | rv_to;
        end
    end

    // Bus fields are only driven while a request is actually presented.
    assign mem_req_o    = (state_q == REQ);
    assign mem_we_o     = mem_req_o & we_q;
    assign mem_addr_o   = mem_req_o ? addr_q : 32'h0;
    assign mem_be_o     = mem_req_o ? be_q : 4'b0000;
    assign mem_wdata_o  = mem_req_o ? wdata_q : 32'h0;
    assign stall_o      = stall_c & ~rst_i;
    assign load_valid_o = load_valid_q;
    assign load_data_o  = load_data_q;
    assign misalign_o   = misalign_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; expected load results are queued
// at issue time and compared when load_valid_o pulses.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misalign;
    logic        timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    load_store_unit #(.TimeoutCycles(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_we_i     (req_we),
        .req_funct3_i (req_f3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .stall_o      (stall),
        .load_valid_o (load_valid),
        .load_data_o  (load_data),
        .misalign_o   (misalign),
        .timeout_o    (timeout),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (gnt),
        .mem_rvalid_i (rvalid),
        .mem_rdata_i  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] ex);
        n_vec++;
        assert (obs === ex) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, ex);
        end
    endtask

    task automatic idle_in();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_f3    = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        gnt       = 1'b0;
        rvalid    = 1'b0;
        rdata     = 32'h0;
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_lv"}, load_valid, 0);
        chk({tag, "_ldata"}, load_data, 0);
        chk({tag, "_mis"}, misalign, 0);
        chk({tag, "_to"}, timeout, 0);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_be"}, mem_be, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    // Scoreboard: every load_valid pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (!rst && load_valid) begin
            if (exp_q.size() == 0)
                chk("lv_unexpected", 32'd1, 32'd0);
            else
                chk("load_data", load_data, exp_q.pop_front());
        end
    end

    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] ex, input logic [3:0] ebe);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_f3    = f3;
        req_addr  = a;
        req_wdata = 32'hFFFF_FFFF;
        exp_q.push_back(ex);
        nedge();
        chk({tag, "_c0_stall"}, stall, 1);
        chk({tag, "_c0_req"}, mem_req, 0);
        next();
        idle_in();
        gnt = 1'b1;
        nedge();
        chk({tag, "_c1_req"}, mem_req, 1);
        chk({tag, "_c1_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_c1_be"}, mem_be, ebe);
        chk({tag, "_c1_we"}, mem_we, 0);
        chk({tag, "_c1_wdata"}, mem_wdata, 0);
        chk({tag, "_c1_stall"}, stall, 1);
        next();
        idle_in();
        rvalid = 1'b1;
        rdata  = rd;
        nedge();
        chk({tag, "_c2_stall"}, stall, 0);
        chk({tag, "_c2_req"}, mem_req, 0);
        next();
        idle_in();
        nedge();
        chk({tag, "_c3_lv"}, load_valid, 1);
        chk({tag, "_c3_stall"}, stall, 0);
        next();
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int nwait, input logic [3:0] ebe,
                            input logic [31:0] ewd);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_f3    = f3;
        req_addr  = a;
        req_wdata = wd;
        nedge();
        chk({tag, "_c0_stall"}, stall, 1);
        chk({tag, "_c0_req"}, mem_req, 0);
        for (int i = 0; i <= nwait; i++) begin
            next();
            idle_in();
            gnt = (i == nwait);
            nedge();
            chk({tag, "_req"}, mem_req, 1);
            chk({tag, "_we"}, mem_we, 1);
            chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
            chk({tag, "_be"}, mem_be, ebe);
            chk({tag, "_wdata"}, mem_wdata, ewd);
            chk({tag, "_stall"}, stall, (i != nwait) ? 1 : 0);
            chk({tag, "_lv"}, load_valid, 0);
        end
        next();
    endtask

    task automatic do_bad(input string tag, input logic we,
                          input logic [2:0] f3, input logic [31:0] a);
        req_valid = 1'b1;
        req_we    = we;
        req_f3    = f3;
        req_addr  = a;
        req_wdata = 32'h1234_5678;
        nedge();
        chk({tag, "_c0_stall"}, stall, 0);
        chk({tag, "_c0_req"}, mem_req, 0);
        next();
        idle_in();
        nedge();
        chk({tag, "_c1_mis"}, misalign, 1);
        chk({tag, "_c1_req"}, mem_req, 0);
        chk({tag, "_c1_stall"}, stall, 0);
        next();
        nedge();
        chk({tag, "_c2_mis"}, misalign, 0);
        next();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle_in();
        req_valid = 1'b1;
        req_f3    = 3'b010;
        req_addr  = 32'h100;
        nedge();
        chk_all_zero("reset");
        next();
        rst = 1'b0;
        idle_in();

        do_load("lw", 3'b010, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);
        do_load("lb", 3'b000, 32'h103, 32'h8011_2233, 32'hFFFF_FF80, 4'b1000);
        do_load("lbu", 3'b100, 32'h103, 32'h8011_2233, 32'h0000_0080, 4'b1000);
        do_load("lhu", 3'b101, 32'h102, 32'h8011_2233, 32'h0000_8011, 4'b1100);
        do_load("lh_hi", 3'b001, 32'h102, 32'h8011_2233, 32'hFFFF_8011, 4'b1100);
        do_load("lh_lo", 3'b001, 32'h100, 32'h8011_2233, 32'h0000_2233, 4'b0011);
        do_load("lb1", 3'b000, 32'h101, 32'h8011_2233, 32'h0000_0022, 4'b0010);

        do_store("sb", 3'b000, 32'h201, 32'h0000_00A5, 3, 4'b0010, 32'hA5A5_A5A5);
        do_store("sh", 3'b001, 32'h202, 32'h1234_BEEF, 0, 4'b1100, 32'hBEEF_BEEF);
        do_store("sw", 3'b010, 32'h300, 32'hCAFE_F00D, 0, 4'b1111, 32'hCAFE_F00D);
        nedge();
        chk("b2b_idle_req", mem_req, 0);
        next();

        do_bad("lw_mis", 1'b0, 3'b010, 32'h102);
        do_bad("sh_mis", 1'b1, 3'b001, 32'h101);
        do_bad("ld_f011", 1'b0, 3'b011, 32'h100);
        do_bad("st_f100", 1'b1, 3'b100, 32'h100);

        // Grant never arrives: abort after four REQ cycles.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_f3    = 3'b010;
        req_addr  = 32'h400;
        nedge();
        chk("to_c0_stall", stall, 1);
        for (int i = 1; i <= 4; i++) begin
            next();
            idle_in();
            nedge();
            chk("to_req", mem_req, 1);
            chk("to_stall", stall, (i < 4) ? 1 : 0);
            chk("to_pulse_early", timeout, 0);
        end
        next();
        nedge();
        chk("to_pulse", timeout, 1);
        chk("to_req_drop", mem_req, 0);
        chk("to_stall_after", stall, 0);
        next();
        rvalid = 1'b1;
        rdata  = 32'h5555_5555;
        nedge();
        chk("to_pulse_width", timeout, 0);
        next();
        idle_in();
        nedge();
        chk("to_late_rvalid", load_valid, 0);
        next();
        do_load("lw_after_to", 3'b010, 32'h404, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111);

        // Reset in WAIT_R aborts the load with no result pulse.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_f3    = 3'b010;
        req_addr  = 32'h500;
        nedge();
        chk("rst_c0_stall", stall, 1);
        next();
        idle_in();
        gnt = 1'b1;
        nedge();
        chk("rst_c1_req", mem_req, 1);
        next();
        idle_in();
        nedge();
        chk("rst_c2_stall", stall, 1);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        rvalid = 1'b1;
        rdata  = 32'h7777_7777;
        next();
        rst = 1'b0;
        idle_in();
        nedge();
        chk("rst_after_lv", load_valid, 0);
        chk("rst_after_req", mem_req, 0);
        next();
        do_store("sw_after_rst", 3'b010, 32'h600, 32'h1357_9BDF, 0, 4'b1111, 32'h1357_9BDF);
        nedge();
        chk("sw_after_rst_idle", mem_req, 0);
        chk("sw_after_rst_lv", load_valid, 0);
        next();

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
